// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and writeback entry type
// for the register-file writeback path.
package rf_pkg;

  localparam int REG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 2 ** REG_W;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input logic [REG_W-1:0] r
  );
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue_if: valid/ready writeback request bundle.
// master = requester, slave = writeback queue.
interface rf_wb_queue_if;
  import rf_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output wb_valid,
    output wb_reg,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_reg,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/rf_wb_queue_fifo.sv
// wb_fifo: circular entry store with head/tail pointers;
// full/empty come from the occupancy count.
module wb_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        wr_entry,
  output wb_entry_t        mem [DEPTH],
  output logic [PTR_W-1:0] head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  wb_entry_t        mem_d [DEPTH];
  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_d, head_q;
  logic [PTR_W-1:0] tail_d, tail_q;
  logic [PTR_W:0]   count_d, count_q;

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = wr_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // state update; reset empties the queue, data is left as is
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign mem   = mem_q;
  assign head  = head_q;
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order writeback queue driving the RF write port.
// Optional youngest-value bypass: define RF_WB_BYPASS_EN.
module rf_wb_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  rf_wb_queue_if.slave        wb,
  input  logic                hold,
  output logic [REG_W-1:0]    writeregsel,
  output logic [DATA_W-1:0]   writedata,
  output logic                write,
  output logic [NUM_REGS-1:0] pend,
  input  logic [REG_W-1:0]    rd_reg1,
  input  logic [REG_W-1:0]    rd_reg2,
  output logic                byp1hit,
  output logic                byp2hit,
  output logic [DATA_W-1:0]   byp1data,
  output logic [DATA_W-1:0]   byp2data
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  wb_entry_t        wr_entry;
  wb_entry_t        head_e;
  logic [PTR_W-1:0] head;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             ready;
  logic             push;
  logic             pop;

  assign pop         = !empty && !hold && !rst;
  assign ready       = !rst && (!full || pop);
  assign push        = wb.wb_valid && ready;
  assign wb.wb_ready = ready;
  assign wr_entry    = '{dst: wb.wb_reg, data: wb.wb_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .mem      (mem),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign head_e = mem[head];

  // register-file port: head entry while draining, else zero
  always_comb begin
    write       = pop;
    writeregsel = '0;
    writedata   = '0;
    if (pop) begin
      writeregsel = head_e.dst;
      writedata   = head_e.data;
    end
  end

  // pending-write mask over valid entries, popping one included
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && (i < int'(count))) begin
        pend |= reg_onehot(mem[head + PTR_W'(i)].dst);
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  // oldest-to-youngest walk; last match is the youngest value
  always_comb begin
    byp1data = '0;
    byp2data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && (i < int'(count))) begin
        if (mem[head + PTR_W'(i)].dst == rd_reg1) begin
          byp1data = mem[head + PTR_W'(i)].data;
        end
        if (mem[head + PTR_W'(i)].dst == rd_reg2) begin
          byp2data = mem[head + PTR_W'(i)].data;
        end
      end
    end
  end

  assign byp1hit = pend[rd_reg1];
  assign byp2hit = pend[rd_reg2];
`else
  logic unused_rd;

  assign unused_rd = ^{rd_reg1, rd_reg2};
  assign byp1hit   = 1'b0;
  assign byp2hit   = 1'b0;
  assign byp1data  = '0;
  assign byp2data  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed steps with a drain scoreboard
// for rf_wb_queue (both RF_WB_BYPASS_EN builds).
module tb_rf_wb_queue;
  import rf_pkg::*;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                hold;
  logic [REG_W-1:0]    writeregsel;
  logic [DATA_W-1:0]   writedata;
  logic                write;
  logic [NUM_REGS-1:0] pend;
  logic [REG_W-1:0]    rd_reg1;
  logic [REG_W-1:0]    rd_reg2;
  logic                byp1hit;
  logic                byp2hit;
  logic [DATA_W-1:0]   byp1data;
  logic [DATA_W-1:0]   byp2data;

  rf_wb_queue_if wb();

  rf_wb_queue #(
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .hold        (hold),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .write       (write),
    .pend        (pend),
    .rd_reg1     (rd_reg1),
    .rd_reg2     (rd_reg2),
    .byp1hit     (byp1hit),
    .byp2hit     (byp2hit),
    .byp1data    (byp1data),
    .byp2data    (byp2data)
  );

  always #5 clk = ~clk;

  wb_entry_t sb[$];
  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wb_entry_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (write) begin
        if (sb.size() == 0) begin
          chk("spurious_write", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("drain_reg", 32'(writeregsel), 32'(e.dst));
          chk("drain_data", 32'(writedata), 32'(e.data));
        end
      end
      if (wb.wb_valid && wb.wb_ready) begin
        sb.push_back('{dst: wb.wb_reg, data: wb.wb_data});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [REG_W-1:0] r,
                     input logic [DATA_W-1:0] d);
    wb.wb_valid = 1'b1;
    wb.wb_reg   = r;
    wb.wb_data  = d;
    #1;
    chk("put_ready", 32'(wb.wb_ready), 32'd1);
    tick();
    wb.wb_valid = 1'b0;
  endtask

  logic [REG_W-1:0] order3 [4];

  initial begin
    rst         = 1'b1;
    hold        = 1'b0;
    wb.wb_valid = 1'b0;
    wb.wb_reg   = '0;
    wb.wb_data  = '0;
    rd_reg1     = '0;
    rd_reg2     = '0;
    order3      = '{3'd2, 3'd3, 3'd4, 3'd6};

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(wb.wb_ready), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_byp1hit", 32'(byp1hit), 32'd0);
    chk("rst_byp1data", 32'(byp1data), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_write", 32'(write), 32'd0);
    chk("post_rst_pend", 32'(pend), 32'd0);
    chk("post_rst_byp2", 32'(byp2hit), 32'd0);

    // single write
    put(3'd3, 16'hBEEF);
    #1;
    chk("t1_write", 32'(write), 32'd1);
    chk("t1_sel", 32'(writeregsel), 32'd3);
    chk("t1_data", 32'(writedata), 32'hBEEF);
    chk("t1_pend", 32'(pend), 32'h08);
    tick();
    chk("t1_write_done", 32'(write), 32'd0);
    chk("t1_pend_done", 32'(pend), 32'h00);

    // fill under hold, then drain in order
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      put(3'(k), 16'(k * 16'h0101));
    end
    wb.wb_valid = 1'b1;
    wb.wb_reg   = 3'd5;
    wb.wb_data  = 16'h5555;
    #1;
    chk("t2_full_ready", 32'(wb.wb_ready), 32'd0);
    chk("t2_pend", 32'(pend), 32'h1E);
    chk("t2_hold_write", 32'(write), 32'd0);
    tick();
    wb.wb_valid = 1'b0;
    hold        = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("t2_write", 32'(write), 32'd1);
      chk("t2_sel", 32'(writeregsel), 32'(k));
      tick();
    end
    chk("t2_idle", 32'(write), 32'd0);

    // full with simultaneous push and pop
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      put(3'(k), 16'(16'hA000 + k));
    end
    hold        = 1'b0;
    wb.wb_valid = 1'b1;
    wb.wb_reg   = 3'd6;
    wb.wb_data  = 16'h6666;
    #1;
    chk("t3_ready", 32'(wb.wb_ready), 32'd1);
    chk("t3_write", 32'(write), 32'd1);
    chk("t3_sel", 32'(writeregsel), 32'd1);
    tick();
    wb.wb_valid = 1'b0;
    #1;
    chk("t3_pend", 32'(pend), 32'h5C);
    for (int k = 0; k < 4; k++) begin
      chk("t3_sel_order", 32'(writeregsel), 32'(order3[k]));
      tick();
    end
    chk("t3_idle", 32'(write), 32'd0);

    // duplicate target and bypass
    hold    = 1'b1;
    rd_reg1 = 3'd5;
    rd_reg2 = 3'd2;
    put(3'd5, 16'h1111);
    put(3'd2, 16'h7777);
    put(3'd5, 16'h2222);
    #1;
    chk("t4_pend", 32'(pend), 32'h24);
    chk("t4_hit1", 32'(byp1hit), 32'(BYP));
    chk("t4_data1", 32'(byp1data), BYP ? 32'h2222 : 32'h0);
    chk("t4_hit2", 32'(byp2hit), 32'(BYP));
    chk("t4_data2", 32'(byp2data), BYP ? 32'h7777 : 32'h0);
    hold = 1'b0;
    #1;
    chk("t4_pop_data1", 32'(byp1data), BYP ? 32'h2222 : 32'h0);
    tick();
    chk("t4_d1_data1", 32'(byp1data), BYP ? 32'h2222 : 32'h0);
    chk("t4_d1_data2", 32'(byp2data), BYP ? 32'h7777 : 32'h0);
    chk("t4_d1_pend", 32'(pend), 32'h24);
    tick();
    chk("t4_d2_hit1", 32'(byp1hit), 32'(BYP));
    chk("t4_d2_data1", 32'(byp1data), BYP ? 32'h2222 : 32'h0);
    chk("t4_d2_hit2", 32'(byp2hit), 32'd0);
    chk("t4_d2_data2", 32'(byp2data), 32'd0);
    tick();
    chk("t4_end_hit1", 32'(byp1hit), 32'd0);
    chk("t4_end_data1", 32'(byp1data), 32'd0);
    chk("t4_end_pend", 32'(pend), 32'd0);

    // reset mid-drain drops queued entries
    hold = 1'b1;
    put(3'd1, 16'hC001);
    put(3'd2, 16'hC002);
    put(3'd3, 16'hC003);
    rst  = 1'b1;
    hold = 1'b0;
    #1;
    chk("t5_rst_write", 32'(write), 32'd0);
    chk("t5_rst_pend", 32'(pend), 32'd0);
    chk("t5_rst_ready", 32'(wb.wb_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_post_write", 32'(write), 32'd0);
    chk("t5_post_pend", 32'(pend), 32'd0);
    repeat (3) begin
      tick();
      chk("t5_no_write", 32'(write), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
